// File: rtl/brq_pkg.sv
// Shared front-end types and helpers for the instruction fetch unit.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package brq_pkg;

    // Aligner buffer occupancy: nothing, a full aligned word, or one upper halfword.
    typedef enum logic [1:0] {
        ALN_EMPTY,
        ALN_FULL,
        ALN_HALF
    } aligner_state_e;

    // A halfword starts a 16-bit instruction unless its two LSBs are both set.
    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/brq_ifu_instr_aligner.sv
// Turns word-aligned fetch words into halfword-aligned instructions with PC and error flags.
// Latency: 1 cycle from fetch word to aligned instruction; a straddling instruction is combinational
// from its second word. Backpressure: in_ready_o is withheld while buffered halfwords still need draining.
// Optional: define BRQ_ALIGNER_BYPASS_EN to forward an aligned word straight from the input when empty.
module brq_ifu_instr_aligner
    import brq_pkg::*;
#(
    parameter logic [31:0] ResetAddr = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o
);

    aligner_state_e state_q, state_d;
    logic        skip_lo_q, skip_lo_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic        werr_q, werr_d;
    logic [15:0] hbuf_q, hbuf_d;
    logic        herr_q, herr_d;
    logic [31:0] addr_q, addr_d;

    logic out_is_c;
    logic out_fire;
    logic in_fire;

    assign out_addr_o = addr_q;

    // Output muxing, handshakes and next-state computation for the buffer.
    always_comb begin
        state_d         = state_q;
        skip_lo_d       = skip_lo_q;
        wbuf_d          = wbuf_q;
        werr_d          = werr_q;
        hbuf_d          = hbuf_q;
        herr_d          = herr_q;
        addr_d          = addr_q;
        out_valid_o     = 1'b0;
        in_ready_o      = 1'b0;
        out_rdata_o     = wbuf_q;
        out_err_o       = werr_q;
        out_err_plus2_o = 1'b0;
        out_is_c        = 1'b0;

        unique case (state_q)
            ALN_EMPTY: begin
                in_ready_o = 1'b1;
`ifdef BRQ_ALIGNER_BYPASS_EN
                if (!skip_lo_q) begin
                    out_valid_o = in_valid_i;
                    out_rdata_o = in_rdata_i;
                    out_err_o   = in_err_i;
                    out_is_c    = is_compressed(in_rdata_i[15:0]);
                end
`endif
            end
            ALN_FULL: begin
                out_valid_o = 1'b1;
                out_rdata_o = wbuf_q;
                out_err_o   = werr_q;
                out_is_c    = is_compressed(wbuf_q[15:0]);
                // The upper halfword of a compressed word still has to drain, so hold the input.
                in_ready_o  = out_ready_i && !out_is_c;
            end
            ALN_HALF: begin
                out_is_c = is_compressed(hbuf_q);
                if (out_is_c) begin
                    out_valid_o = 1'b1;
                    out_rdata_o = {16'h0000, hbuf_q};
                    out_err_o   = herr_q;
                    in_ready_o  = out_ready_i;
                end else begin
                    // Straddling instruction: lower half comes straight from the incoming word.
                    out_valid_o     = in_valid_i;
                    out_rdata_o     = {in_rdata_i[15:0], hbuf_q};
                    out_err_o       = herr_q | in_err_i;
                    out_err_plus2_o = !herr_q & in_err_i;
                    in_ready_o      = out_ready_i;
                end
            end
            default: begin
                in_ready_o = 1'b1;
            end
        endcase

        // A redirect discards everything in flight, including the word on the input.
        if (redirect_i) begin
            out_valid_o = 1'b0;
            in_ready_o  = 1'b1;
        end

        out_fire = out_valid_o && out_ready_i;
        in_fire  = in_valid_i && in_ready_o;

        if (redirect_i) begin
            state_d   = ALN_EMPTY;
            skip_lo_d = redirect_addr_i[1];
            addr_d    = {redirect_addr_i[31:1], 1'b0};
        end else begin
            if (out_fire) begin
                addr_d = addr_q + (out_is_c ? 32'd2 : 32'd4);
            end
            unique case (state_q)
                ALN_EMPTY: begin
                    if (in_fire) begin
                        if (skip_lo_q) begin
                            hbuf_d    = in_rdata_i[31:16];
                            herr_d    = in_err_i;
                            skip_lo_d = 1'b0;
                            state_d   = ALN_HALF;
                        end else begin
`ifdef BRQ_ALIGNER_BYPASS_EN
                            if (out_fire && out_is_c) begin
                                hbuf_d  = in_rdata_i[31:16];
                                herr_d  = in_err_i;
                                state_d = ALN_HALF;
                            end else if (!out_fire) begin
                                wbuf_d  = in_rdata_i;
                                werr_d  = in_err_i;
                                state_d = ALN_FULL;
                            end
`else
                            wbuf_d  = in_rdata_i;
                            werr_d  = in_err_i;
                            state_d = ALN_FULL;
`endif
                        end
                    end
                end
                ALN_FULL: begin
                    if (out_fire) begin
                        if (out_is_c) begin
                            hbuf_d  = wbuf_q[31:16];
                            herr_d  = werr_q;
                            state_d = ALN_HALF;
                        end else if (in_fire) begin
                            wbuf_d  = in_rdata_i;
                            werr_d  = in_err_i;
                        end else begin
                            state_d = ALN_EMPTY;
                        end
                    end
                end
                ALN_HALF: begin
                    if (out_fire) begin
                        if (out_is_c) begin
                            if (in_fire) begin
                                wbuf_d  = in_rdata_i;
                                werr_d  = in_err_i;
                                state_d = ALN_FULL;
                            end else begin
                                state_d = ALN_EMPTY;
                            end
                        end else begin
                            // Upper half of the consumed word becomes the next pending halfword.
                            hbuf_d = in_rdata_i[31:16];
                            herr_d = in_err_i;
                        end
                    end
                end
                default: begin
                    state_d = ALN_EMPTY;
                end
            endcase
        end
    end

    // Buffer, skip flag and PC registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ALN_EMPTY;
            skip_lo_q <= 1'b0;
            wbuf_q    <= 32'h0;
            werr_q    <= 1'b0;
            hbuf_q    <= 16'h0;
            herr_q    <= 1'b0;
            addr_q    <= ResetAddr;
        end else begin
            state_q   <= state_d;
            skip_lo_q <= skip_lo_d;
            wbuf_q    <= wbuf_d;
            werr_q    <= werr_d;
            hbuf_q    <= hbuf_d;
            herr_q    <= herr_d;
            addr_q    <= addr_d;
        end
    end

endmodule

// File: tb/tb_brq_ifu_instr_aligner.sv
// Directed table-driven bench for the instruction aligner (default build, no bypass).
// Each vector is one cycle: inputs driven after the falling edge, outputs checked before the rising edge.
// Hand sequences cover reset state and asynchronous reset while a halfword is buffered.
module tb_brq_ifu_instr_aligner;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rdata;
    logic        in_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [31:0] out_addr;
    logic        out_err;
    logic        out_err_plus2;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        redir;
        logic [31:0] raddr;
        logic        iv;
        logic [31:0] idat;
        logic        ierr;
        logic        ordy;
        logic        e_irdy;
        logic        e_ov;
        logic [31:0] e_odat;
        logic [31:0] e_oaddr;
        logic        e_err;
        logic        e_p2;
    } vec_t;

    vec_t vecs[$];

    brq_ifu_instr_aligner #(
        .ResetAddr(32'h0000_0000)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .redirect_i      (redirect),
        .redirect_addr_i (redirect_addr),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_rdata_i      (in_rdata),
        .in_err_i        (in_err),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_rdata_o     (out_rdata),
        .out_addr_o      (out_addr),
        .out_err_o       (out_err),
        .out_err_plus2_o (out_err_plus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic redir, input logic [31:0] raddr, input logic iv,
                       input logic [31:0] idat, input logic ierr, input logic ordy,
                       input logic e_irdy, input logic e_ov, input logic [31:0] e_odat,
                       input logic [31:0] e_oaddr, input logic e_err, input logic e_p2);
        vec_t v;
        v.redir = redir;   v.raddr = raddr;     v.iv = iv;         v.idat = idat;
        v.ierr = ierr;     v.ordy = ordy;       v.e_irdy = e_irdy; v.e_ov = e_ov;
        v.e_odat = e_odat; v.e_oaddr = e_oaddr; v.e_err = e_err;   v.e_p2 = e_p2;
        vecs.push_back(v);
    endtask

    // Compare one cycle; data and error fields only matter when an instruction is presented.
    task automatic check_vec(input int idx, input vec_t v);
        logic ok;
        ok = (in_ready === v.e_irdy) && (out_valid === v.e_ov) && (out_addr === v.e_oaddr);
        if (v.e_ov)
            ok = ok && (out_rdata === v.e_odat) && (out_err === v.e_err) && (out_err_plus2 === v.e_p2);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL vec%0d: got irdy=%b ov=%b od=%h oa=%h err=%b p2=%b, want irdy=%b ov=%b od=%h oa=%h err=%b p2=%b",
                     idx, in_ready, out_valid, out_rdata, out_addr, out_err, out_err_plus2,
                     v.e_irdy, v.e_ov, v.e_odat, v.e_oaddr, v.e_err, v.e_p2);
        end
    endtask

    task automatic check_bits(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 32'h0;
        in_valid      = 1'b0;
        in_rdata      = 32'h0;
        in_err        = 1'b0;
        out_ready     = 1'b0;

        //  redir raddr         iv idat          ie or  | irdy ov odat          oaddr         err p2
        // Two aligned 32-bit instructions after a redirect.
        add(1, 32'h0000_0100, 0, 32'h0,         0, 1,   1, 0, 32'h0,         32'h0000_0000, 0, 0);
        add(0, 32'h0,         1, 32'h00A0_0093, 0, 1,   1, 0, 32'h0,         32'h0000_0100, 0, 0);
        add(0, 32'h0,         1, 32'h00B0_0113, 0, 1,   1, 1, 32'h00A0_0093, 32'h0000_0100, 0, 0);
        add(0, 32'h0,         0, 32'h0,         0, 1,   1, 1, 32'h00B0_0113, 32'h0000_0104, 0, 0);
        add(0, 32'h0,         0, 32'h0,         0, 1,   1, 0, 32'h0,         32'h0000_0108, 0, 0);
        // Two c.li in one word; input stalled while the upper one drains.
        add(1, 32'h0000_0000, 1, 32'hDEAD_BEEF, 0, 1,   1, 0, 32'h0,         32'h0000_0108, 0, 0);
        add(0, 32'h0,         1, 32'h4501_4505, 0, 1,   1, 0, 32'h0,         32'h0000_0000, 0, 0);
        add(0, 32'h0,         1, 32'h00A0_0093, 0, 1,   0, 1, 32'h4501_4505, 32'h0000_0000, 0, 0);
        add(0, 32'h0,         1, 32'h00A0_0093, 0, 1,   1, 1, 32'h0000_4501, 32'h0000_0002, 0, 0);
        add(0, 32'h0,         0, 32'h0,         0, 1,   1, 1, 32'h00A0_0093, 32'h0000_0004, 0, 0);
        // Redirect to an odd halfword; straddling instruction stitched from two words.
        add(1, 32'h0000_0202, 0, 32'h0,         0, 1,   1, 0, 32'h0,         32'h0000_0008, 0, 0);
        add(0, 32'h0,         1, 32'h0093_1234, 0, 1,   1, 0, 32'h0,         32'h0000_0202, 0, 0);
        add(0, 32'h0,         1, 32'h5678_00A0, 0, 1,   1, 1, 32'h00A0_0093, 32'h0000_0202, 0, 0);
        add(0, 32'h0,         0, 32'h0,         0, 1,   1, 1, 32'h0000_5678, 32'h0000_0206, 0, 0);
        add(0, 32'h0,         0, 32'h0,         0, 1,   1, 0, 32'h0,         32'h0000_0208, 0, 0);
        // Straddle with the second word erroneous, then with the first word erroneous.
        add(1, 32'h0000_0302, 0, 32'h0,         0, 1,   1, 0, 32'h0,         32'h0000_0208, 0, 0);
        add(0, 32'h0,         1, 32'h0093_0000, 0, 1,   1, 0, 32'h0,         32'h0000_0302, 0, 0);
        add(0, 32'h0,         1, 32'h0000_00A0, 1, 1,   1, 1, 32'h00A0_0093, 32'h0000_0302, 1, 1);
        add(0, 32'h0,         0, 32'h0,         0, 0,   0, 1, 32'h0000_0000, 32'h0000_0306, 1, 0);
        add(1, 32'h0000_0402, 0, 32'h0,         0, 1,   1, 0, 32'h0,         32'h0000_0306, 0, 0);
        add(0, 32'h0,         1, 32'h0093_0000, 1, 1,   1, 0, 32'h0,         32'h0000_0402, 0, 0);
        add(0, 32'h0,         1, 32'h0000_00A0, 0, 1,   1, 1, 32'h00A0_0093, 32'h0000_0402, 1, 0);
        add(1, 32'h0000_0000, 0, 32'h0,         0, 1,   1, 0, 32'h0,         32'h0000_0406, 0, 0);
        // Backpressure: five stalled cycles in FULL, then in-order continuation.
        add(0, 32'h0,         1, 32'h00A0_0093, 0, 0,   1, 0, 32'h0,         32'h0000_0000, 0, 0);
        for (int k = 0; k < 5; k++)
            add(0, 32'h0,     1, 32'h00B0_0113, 0, 0,   0, 1, 32'h00A0_0093, 32'h0000_0000, 0, 0);
        add(0, 32'h0,         1, 32'h00B0_0113, 0, 1,   1, 1, 32'h00A0_0093, 32'h0000_0000, 0, 0);
        add(0, 32'h0,         0, 32'h0,         0, 1,   1, 1, 32'h00B0_0113, 32'h0000_0004, 0, 0);
        // Redirect coincident with would-be out fire and in fire: no PC step, word dropped.
        add(0, 32'h0,         1, 32'h00C0_0193, 0, 1,   1, 0, 32'h0,         32'h0000_0008, 0, 0);
        add(1, 32'h0000_0500, 1, 32'h00D0_0213, 0, 1,   1, 0, 32'h0,         32'h0000_0008, 0, 0);
        add(0, 32'h0,         0, 32'h0,         0, 1,   1, 0, 32'h0,         32'h0000_0500, 0, 0);

        // Reset state.
        #3;
        check_bits("rst_in_ready",  {31'h0, in_ready},  32'h1);
        check_bits("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check_bits("rst_out_addr",  out_addr,           32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            redirect      = vecs[i].redir;
            redirect_addr = vecs[i].raddr;
            in_valid      = vecs[i].iv;
            in_rdata      = vecs[i].idat;
            in_err        = vecs[i].ierr;
            out_ready     = vecs[i].ordy;
            #2;
            check_vec(i, vecs[i]);
        end

        // Asynchronous reset while a compressed halfword is buffered.
        @(negedge clk);
        redirect = 1'b1; redirect_addr = 32'h0000_0602; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        redirect = 1'b0; in_valid = 1'b1; in_rdata = 32'h4501_0000; in_err = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        check_bits("half_valid", {31'h0, out_valid}, 32'h1);
        check_bits("half_rdata", out_rdata,          32'h0000_4501);
        check_bits("half_addr",  out_addr,           32'h0000_0602);
        #1;
        rst_n = 1'b0;
        #1;
        check_bits("midrst_valid", {31'h0, out_valid}, 32'h0);
        check_bits("midrst_ready", {31'h0, in_ready},  32'h1);
        check_bits("midrst_addr",  out_addr,           32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_rdata = 32'h00A0_0093; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        check_bits("postrst_valid", {31'h0, out_valid}, 32'h1);
        check_bits("postrst_rdata", out_rdata,          32'h00A0_0093);
        check_bits("postrst_addr",  out_addr,           32'h0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/brq_ifu_instr_aligner.md
Name: brq_ifu_instr_aligner

Overview:
- Sits between the fetch FIFO/prefetch buffer and brq_ifu_compressed_decoder.
- Takes word-aligned 32-bit fetch words over a valid/ready handshake.
- Emits halfword-aligned instruction bits, address and error flags, one instruction per handshake.
- Stitches 32-bit instructions that straddle two fetch words and tracks the instruction PC.

Parameters:
- ResetAddr, 32'h0000_0000, value of out_addr_o after reset.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- redirect_i  in  1  flush and restart at redirect_addr_i
- redirect_addr_i  in  32  new PC; bit0 ignored
- in_valid_i  in  1  fetch word valid
- in_ready_o  out  1  aligner accepts fetch word
- in_rdata_i  in  32  word-aligned fetch data
- in_err_i  in  1  bus error on this word
- out_valid_o  out  1  instruction available
- out_ready_i  in  1  downstream accepts
- out_rdata_o  out  32  instruction bits; [15:0] only meaningful if compressed
- out_addr_o  out  32  PC of out_rdata_o
- out_err_o  out  1  fetch error on any halfword used
- out_err_plus2_o  out  1  error only on the second halfword of an unaligned 32-bit instr

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: state=EMPTY, skip_lo=0, out_addr_o=ResetAddr. out_valid_o=0 and in_ready_o=1 during reset.
- Compressed test: halfword h is compressed iff h[1:0]!=2'b11.
- Fire events: out fire = out_valid_o&&out_ready_i. In fire = in_valid_i&&in_ready_o.
- State EMPTY (no buffered data):
  - in_ready_o=1.
  - On in fire with skip_lo=1: hbuf=in[31:16], herr=in_err_i, go HALF, clear skip_lo.
  - On in fire with skip_lo=0: wbuf=word, go FULL.
  - No output from EMPTY (see optional feature).
- State FULL (wbuf holds an aligned word):
  - out_rdata_o=wbuf, out_err_o=werr, out_valid_o=1.
  - Compressed fire: hbuf=wbuf[31:16], go HALF, in_ready_o=0.
  - Uncompressed fire: in_ready_o=1. Load FULL if in fire, else go EMPTY.
- State HALF (hbuf holds an upper halfword):
  - If hbuf is compressed:
    - out_rdata_o={16'h0,hbuf}, out_valid_o=1, out_err_o=herr.
    - in_ready_o=out fire; on fire go FULL if in fire, else EMPTY.
  - If hbuf is uncompressed:
    - out_rdata_o={in[15:0],hbuf}, out_valid_o=in_valid_i.
    - out_err_o=herr|in_err_i; out_err_plus2_o=!herr&in_err_i.
    - in_ready_o=out_ready_i; on fire hbuf=in[31:16], herr=in_err_i, stay HALF.
  - out_err_plus2_o=0 in every other case.
- PC: on out fire, out_addr_o += 2 if compressed, else += 4.
- Redirect (highest priority):
  - out_addr_o=redirect_addr_i&~1, state=EMPTY, skip_lo=redirect_addr_i[1].
  - out_valid_o forced 0 in that cycle; in_ready_o=1 and the incoming word is dropped.
- Erroneous words advance like normal data. The downstream stage acts on out_err_o.
- Latency: aligned instruction is 1 cycle after in fire. Straddling instruction is combinational from the second word in HALF.
- Throughput: sustains one instruction per cycle for any mix of compressed and uncompressed instructions.

Optional Feature:
- Macro: BRQ_ALIGNER_BYPASS_EN.
- Defined: in EMPTY with skip_lo=0, in_rdata_i/in_err_i drive outputs combinationally and out_valid_o=in_valid_i.
  - Uncompressed fire stays EMPTY.
  - Compressed fire goes HALF with hbuf=in[31:16].
  - No out fire: word loads FULL.
  - Aligned-start latency 0 cycles.
- Undefined: EMPTY never outputs; behaviour as above; 1-cycle latency.

Decomposition:
- brq_pkg: typedef enum logic [1:0] {ALN_EMPTY, ALN_FULL, ALN_HALF} aligner_state_e.
- brq_pkg: function is_compressed(logic [15:0]), shared with the decoder and the controller.
- No sub-module: one flat sequential module.

Test Plan:
- Reset, redirect to 0x100, words 0x00A00093 then 0x00B00113 -> two outputs, addr 0x100 then 0x104, no error.
- Word 0x4501_4505 (two c.li) -> compressed 0x4505 at 0x0, 0x4501 at 0x2. in_ready_o=0 while draining HALF.
- Redirect to 0x202, word 0x0093_xxxx, then word 0xyyyy_00A0 -> single output 0x00A00093 at 0x202. Lower halfword of the first word discarded.
- Straddle case with second word in_err_i=1 -> out_err_o=1, out_err_plus2_o=1, addr unchanged. Same case with the first word erroneous -> out_err_plus2_o=0.
- out_ready_i held 0 for 5 cycles in FULL -> outputs stable, in_ready_o=0, no word lost. Release -> in-order continuation.
- Redirect asserted same cycle as out fire and in fire -> no PC increment, word dropped, out_addr_o=redirect_addr_i; reset asserted mid-HALF -> EMPTY, addr=ResetAddr.
